// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - sequencer <-> datapath strobe/status bundle
interface control_sequencer_if;
  logic [31:0] IR;
  logic        CON_FF;
  logic [21:0] ctrl;
  logic [4:0]  alu_op;
  logic [3:0]  state_out;
  logic        run;
  logic        illegal;

  modport master (
    input  IR, CON_FF,
    output ctrl, alu_op, state_out, run, illegal
  );

  modport slave (
    output IR, CON_FF,
    input  ctrl, alu_op, state_out, run, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired T0..T7 control unit; optional ILLEGAL_TRAP_EN halts on unknown opcodes
module control_sequencer #(
  parameter int MEM_WAIT = 0
) (
  input logic                 Clock,
  input logic                 Clear,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET = 4'b0000, S_T0 = 4'b0001, S_T1 = 4'b0010, S_T2 = 4'b0011,
    S_T3    = 4'b0100, S_T4 = 4'b0101, S_T5 = 4'b0110, S_T6 = 4'b0111,
    S_T7    = 4'b1000, S_HALT = 4'b1111
  } state_t;

  localparam logic [4:0] OP_LDW  = 5'b00000, OP_LDWI = 5'b00001, OP_STW  = 5'b00010,
                         OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b01001,
                         OP_OR   = 5'b01010, OP_ADDI = 5'b01011, OP_BR   = 5'b10010,
                         OP_NOP  = 5'b11001, OP_HALT = 5'b11010;

  localparam int B_PCOUT = 0,  B_ZLOWOUT = 1, B_ZHIGHOUT = 2, B_MDROUT = 3, B_MAR_EN = 4,
                 B_PC_EN = 5,  B_MDR_EN = 6,  B_MDR_READ = 7, B_RAM_WR = 8, B_IR_EN = 9,
                 B_Y_EN  = 10, B_INCPC = 11,  B_ZLOWIN = 12,  B_ZHIGHIN = 13, B_GRA = 14,
                 B_GRB   = 15, B_GRC = 16,    B_R_IN = 17,    B_R_OUT = 18, B_BAOUT = 19,
                 B_COUT  = 20, B_CON_EN = 21;

  localparam int WW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  state_t        state, next_state;
  logic [4:0]    opcode;
  logic [WW-1:0] wait_cnt;
  logic          wait_last;
  logic          in_wait;
  logic          op_listed;
  logic [21:0]   ctrl_v;
  logic [4:0]    alu_v;
  logic          unused_ir_bits;

  assign unused_ir_bits = ^bus.IR[26:0];
  assign wait_last      = (wait_cnt == WW'(MEM_WAIT));
  assign in_wait        = (state == S_T1) || (state == S_T6 && opcode == OP_LDW);

  // Opcodes with a defined execute sequence; anything else is a nop or a trap
  always_comb begin
    case (opcode)
      OP_LDW, OP_LDWI, OP_STW, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_BR, OP_NOP, OP_HALT: op_listed = 1'b1;
      default:                         op_listed = 1'b0;
    endcase
  end

  // State register, memory wait counter and opcode latch (captured on T2->T3)
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state    <= S_RESET;
      wait_cnt <= '0;
      opcode   <= '0;
    end else begin
      state <= next_state;
      if (in_wait && !wait_last) wait_cnt <= wait_cnt + WW'(1);
      else                       wait_cnt <= '0;
      if (state == S_T2) opcode <= bus.IR[31:27];
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  // Sticky trap flag, only Clear removes it
  always_ff @(posedge Clock) begin
    if (Clear)                          illegal_q <= 1'b0;
    else if (state == S_T3 && !op_listed) illegal_q <= 1'b1;
  end
  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  // Next-state and Moore strobe decode from state, latched opcode and CON_FF
  always_comb begin
    ctrl_v     = '0;
    alu_v      = 5'b00011;
    next_state = state;
    case (state)
      S_RESET: next_state = S_T0;
      S_T0: begin
        ctrl_v[B_PCOUT] = 1'b1; ctrl_v[B_MAR_EN] = 1'b1;
        ctrl_v[B_INCPC] = 1'b1; ctrl_v[B_ZLOWIN] = 1'b1;
        next_state = S_T1;
      end
      S_T1: begin
        ctrl_v[B_MDR_READ] = 1'b1; ctrl_v[B_MDR_EN] = 1'b1;
        if (wait_last) begin
          // PC loads from Z only once, on the last cycle of the read
          ctrl_v[B_ZLOWOUT] = 1'b1; ctrl_v[B_PC_EN] = 1'b1;
          next_state = S_T2;
        end
      end
      S_T2: begin
        ctrl_v[B_MDROUT] = 1'b1; ctrl_v[B_IR_EN] = 1'b1;
        next_state = S_T3;
      end
      S_T3: begin
        next_state = S_T4;
        case (opcode)
          OP_LDW, OP_LDWI, OP_STW: begin
            ctrl_v[B_GRB] = 1'b1; ctrl_v[B_BAOUT] = 1'b1; ctrl_v[B_Y_EN] = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
            ctrl_v[B_GRB] = 1'b1; ctrl_v[B_R_OUT] = 1'b1; ctrl_v[B_Y_EN] = 1'b1;
          end
          OP_BR: begin
            ctrl_v[B_GRA] = 1'b1; ctrl_v[B_R_OUT] = 1'b1; ctrl_v[B_CON_EN] = 1'b1;
          end
          OP_NOP:  next_state = S_T0;
          OP_HALT: next_state = S_HALT;
`ifdef ILLEGAL_TRAP_EN
          default: next_state = S_HALT;
`else
          default: next_state = S_T0;
`endif
        endcase
      end
      S_T4: begin
        next_state = S_T5;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            ctrl_v[B_GRC] = 1'b1; ctrl_v[B_R_OUT] = 1'b1; ctrl_v[B_ZLOWIN] = 1'b1;
            alu_v = opcode;
          end
          OP_BR: begin
            ctrl_v[B_PCOUT] = 1'b1; ctrl_v[B_Y_EN] = 1'b1;
          end
          default: begin
            ctrl_v[B_COUT] = 1'b1; ctrl_v[B_ZLOWIN] = 1'b1;
          end
        endcase
      end
      S_T5: begin
        next_state = S_T0;
        case (opcode)
          OP_LDW, OP_STW: begin
            ctrl_v[B_ZLOWOUT] = 1'b1; ctrl_v[B_MAR_EN] = 1'b1;
            next_state = S_T6;
          end
          OP_BR: begin
            ctrl_v[B_COUT] = 1'b1; ctrl_v[B_ZLOWIN] = 1'b1;
            next_state = S_T6;
          end
          default: begin
            ctrl_v[B_ZLOWOUT] = 1'b1; ctrl_v[B_GRA] = 1'b1; ctrl_v[B_R_IN] = 1'b1;
          end
        endcase
      end
      S_T6: begin
        next_state = S_T0;
        case (opcode)
          OP_LDW: begin
            ctrl_v[B_MDR_READ] = 1'b1; ctrl_v[B_MDR_EN] = 1'b1;
            next_state = wait_last ? S_T7 : S_T6;
          end
          OP_STW: begin
            ctrl_v[B_GRA] = 1'b1; ctrl_v[B_R_OUT] = 1'b1; ctrl_v[B_MDR_EN] = 1'b1;
            next_state = S_T7;
          end
          OP_BR: begin
            ctrl_v[B_ZLOWOUT] = 1'b1; ctrl_v[B_PC_EN] = bus.CON_FF;
          end
          default: ;
        endcase
      end
      S_T7: begin
        next_state = S_T0;
        if (opcode == OP_LDW) begin
          ctrl_v[B_MDROUT] = 1'b1; ctrl_v[B_GRA] = 1'b1; ctrl_v[B_R_IN] = 1'b1;
        end else if (opcode == OP_STW) begin
          ctrl_v[B_RAM_WR] = 1'b1;
        end
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_RESET;
    endcase
  end

  assign bus.ctrl      = ctrl_v;
  assign bus.alu_op    = alu_v;
  assign bus.state_out = state;
  assign bus.run       = (state != S_RESET) && (state != S_HALT);

endmodule
